// File: rtl/timer_pkg.sv
// Field limits and widths of the countdown timer, shared by the count datapath,
// control FSM and display decoder.
package timer_pkg;

  localparam int unsigned MS_MAX  = 999;
  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;
  localparam int unsigned HR_MAX  = 23;

  localparam int unsigned MS_W  = 10;
  localparam int unsigned SEC_W = 6;
  localparam int unsigned MIN_W = 6;
  localparam int unsigned HR_W  = 5;

endpackage

// File: rtl/timer_field_counter.sv
// One wrapping time field (0..MAX) with inc/dec enables and same-cycle
// carry/borrow flags for chaining by the control FSM.
module timer_field_counter #(
  parameter int unsigned MAX = 59,
  parameter int unsigned W   = 6
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clear,
  input  logic         i_en_inc,
  input  logic         i_en_dec,
  output logic [W-1:0] o_val,
  output logic         o_carryup,
  output logic         o_borrowdown
);

  logic [W-1:0] val_q;
  logic         at_max;
  logic         at_zero;
  logic         out_of_range;

  assign at_max       = (val_q == W'(MAX));
  assign at_zero      = (val_q == '0);
  assign out_of_range = (val_q > W'(MAX));

  // Out-of-range values (only reachable by forcing) fall back to 0 on any step.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      val_q <= '0;
    end else if (i_clear) begin
      val_q <= '0;
    end else if (i_en_inc) begin
      val_q <= (at_max || out_of_range) ? '0 : val_q + W'(1);
    end else if (i_en_dec) begin
      if (at_zero)           val_q <= W'(MAX);
      else if (out_of_range) val_q <= '0;
      else                   val_q <= val_q - W'(1);
    end
  end

  assign o_val        = val_q;
  assign o_carryup    = i_en_inc & ~i_clear & ~i_rst & at_max;
  assign o_borrowdown = i_en_dec & ~i_clear & ~i_rst & at_zero;

endmodule

// File: rtl/timer_counter.sv
// Countdown timer count datapath: ms/sec/min/hr fields, strobe gating and
// the prescaler that paces the ms field.
module timer_counter
  import timer_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned TICK_HZ     = 1000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_ms_up,
  input  logic             i_ms_down,
  input  logic             i_sec_up,
  input  logic             i_sec_down,
  input  logic             i_min_up,
  input  logic             i_min_down,
  input  logic             i_hr_up,
  input  logic             i_hr_down,
  output logic [MS_W-1:0]  o_ms,
  output logic [SEC_W-1:0] o_sec,
  output logic [MIN_W-1:0] o_min,
  output logic [HR_W-1:0]  o_hr,
  output logic             o_ms_borrowdown,
  output logic             o_sec_borrowdown,
  output logic             o_min_borrowdown,
  output logic             o_hr_borrowdown,
  output logic             o_ms_carryup,
  output logic             o_sec_carryup,
  output logic             o_min_carryup,
  output logic             o_hr_carryup,
  output logic             o_tick
);

  localparam int unsigned DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int unsigned PW  = $clog2(DIV);

  logic [PW-1:0] presc_q;
  logic          presc_wrap;

  assign presc_wrap = (presc_q == PW'(DIV - 1));

  // Free-running prescaler; neither clear nor strobes disturb its phase.
  always_ff @(posedge i_clk) begin
    if (i_rst)           presc_q <= '0;
    else if (presc_wrap) presc_q <= '0;
    else                 presc_q <= presc_q + PW'(1);
  end

  assign o_tick = presc_wrap;

  logic ms_inc, ms_dec, sec_inc, sec_dec, min_inc, min_dec, hr_inc, hr_dec;

  // Opposing strobes cancel; the ms field only moves on tick cycles.
  assign ms_inc  = i_ms_up    & ~i_ms_down  & o_tick;
  assign ms_dec  = i_ms_down  & ~i_ms_up    & o_tick;
  assign sec_inc = i_sec_up   & ~i_sec_down;
  assign sec_dec = i_sec_down & ~i_sec_up;
  assign min_inc = i_min_up   & ~i_min_down;
  assign min_dec = i_min_down & ~i_min_up;
  assign hr_inc  = i_hr_up    & ~i_hr_down;
  assign hr_dec  = i_hr_down  & ~i_hr_up;

  timer_field_counter #(.MAX(MS_MAX), .W(MS_W)) u_ms (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (i_clear),
    .i_en_inc     (ms_inc),
    .i_en_dec     (ms_dec),
    .o_val        (o_ms),
    .o_carryup    (o_ms_carryup),
    .o_borrowdown (o_ms_borrowdown)
  );

  timer_field_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (i_clear),
    .i_en_inc     (sec_inc),
    .i_en_dec     (sec_dec),
    .o_val        (o_sec),
    .o_carryup    (o_sec_carryup),
    .o_borrowdown (o_sec_borrowdown)
  );

  timer_field_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (i_clear),
    .i_en_inc     (min_inc),
    .i_en_dec     (min_dec),
    .o_val        (o_min),
    .o_carryup    (o_min_carryup),
    .o_borrowdown (o_min_borrowdown)
  );

  timer_field_counter #(.MAX(HR_MAX), .W(HR_W)) u_hr (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (i_clear),
    .i_en_inc     (hr_inc),
    .i_en_dec     (hr_dec),
    .o_val        (o_hr),
    .o_carryup    (o_hr_carryup),
    .o_borrowdown (o_hr_borrowdown)
  );

endmodule
